regfile_mp_sb: RTL and testbench

Parametrised multi-port general register file with a per-register pending-write scoreboard and a registered write-trace port. It sits in the decode stage of the pipelined CPU. It provides NUM_RD combinational read ports with same-cycle write-through forwarding and NUM_WR writeback ports. An issue interface marks destinations busy so hazard logic can stall on `rd_busy` instead of comparing pipeline-stage addresses.

---
 rtl/regfile_pkg.sv | 45 ++++
 rtl/regfile_scoreboard.sv | 118 +++++++++++
 rtl/regfile_mp_sb.sv | 142 ++++++++++++++
 tb/tb_regfile_mp_sb.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared widths, forwarding-hit type and write-port match helper
//               for the multi-port register file with scoreboard.
// Revision    : 1.0  initial release
// ============================================================================
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_NUM_RD = 2;
    localparam int DEF_NUM_WR = 2;
    localparam int DEF_CNT_W  = 2;

    // Upper bounds for the padded vectors handed to idx_hit; callers zero-pad
    // unused ports so they can never match.
    localparam int MAX_ADDR_W = 8;
    localparam int MAX_WR     = 8;
    localparam int HIT_IDX_W  = 3;

    typedef struct packed {
        logic                 hit;
        logic [HIT_IDX_W-1:0] idx;
    } hit_t;

    // Highest-index enabled write port whose address equals addr.
    function automatic hit_t idx_hit(
        input logic [MAX_ADDR_W-1:0]        addr,
        input logic [MAX_WR-1:0]            wr_en,
        input logic [MAX_WR*MAX_ADDR_W-1:0] wr_addr
    );
        hit_t res;
        res = '0;
        for (int j = 0; j < MAX_WR; j++) begin
            if (wr_en[j] && (wr_addr[j*MAX_ADDR_W +: MAX_ADDR_W] == addr)) begin
                res.hit = 1'b1;
                res.idx = HIT_IDX_W'(j);
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : regfile_scoreboard
// Description : Per-register pending-write counters, issue back-pressure,
//               busy flags for read ports and sticky underflow flag.
// Revision    : 1.0  initial release
// ============================================================================
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = DEF_NUM_RD,
    parameter int NUM_WR = DEF_NUM_WR,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR-1:0]        wr_clr,
    input  logic                     iss_valid,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic                     iss_ready,
    output logic                     sb_err
);

    localparam int DEPTH = 2**ADDR_W;
    localparam int CLR_W = $clog2(NUM_WR + 1);
    // Wide enough for count + issue without overflow before the clear subtract.
    localparam int SUM_W = CNT_W + CLR_W + 1;
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_cnt     [DEPTH];
    logic [CNT_W-1:0] w_cnt_nxt [DEPTH];
    logic [CLR_W-1:0] w_clr_cnt [DEPTH];
    logic [SUM_W-1:0] w_up;
    logic [SUM_W-1:0] w_dn;
    logic             w_uflow;
    logic             w_iss_ready;
    logic             w_iss_acc;
    logic             r_sb_err;

    // Count how many retiring writes target each register this cycle.
    always_comb begin
        for (int r = 0; r < DEPTH; r++) begin
            w_clr_cnt[r] = '0;
        end
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en[j] && wr_clr[j] && (wr_addr[j*ADDR_W +: ADDR_W] != '0)) begin
                w_clr_cnt[wr_addr[j*ADDR_W +: ADDR_W]] =
                    w_clr_cnt[wr_addr[j*ADDR_W +: ADDR_W]] + CLR_W'(1);
            end
        end
    end

    // Issue is refused only when the counter is full and nothing retires it.
    always_comb begin
        w_iss_ready = 1'b1;
        if (!reset && (iss_addr != '0) && (r_cnt[iss_addr] == c_CNT_MAX) &&
            (w_clr_cnt[iss_addr] == '0)) begin
            w_iss_ready = 1'b0;
        end
        w_iss_acc = iss_valid && w_iss_ready && (iss_addr != '0);
    end

    assign iss_ready = w_iss_ready;

    // Next counter values with saturation at zero and underflow detection.
    always_comb begin
        w_uflow      = 1'b0;
        w_up         = '0;
        w_dn         = '0;
        w_cnt_nxt[0] = '0;
        for (int r = 1; r < DEPTH; r++) begin
            w_up = SUM_W'(r_cnt[r]) + SUM_W'(w_iss_acc && (iss_addr == ADDR_W'(r)));
            w_dn = SUM_W'(w_clr_cnt[r]);
            if (w_dn > w_up) begin
                w_cnt_nxt[r] = '0;
                w_uflow      = 1'b1;
            end else begin
                w_cnt_nxt[r] = CNT_W'(w_up - w_dn);
            end
        end
    end

    // Busy means writes remain outstanding after this cycle's retirements.
    always_comb begin
        rd_busy = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            rd_busy[i] = (rd_addr[i*ADDR_W +: ADDR_W] != '0) &&
                         (SUM_W'(r_cnt[rd_addr[i*ADDR_W +: ADDR_W]]) >
                          SUM_W'(w_clr_cnt[rd_addr[i*ADDR_W +: ADDR_W]]));
        end
    end

    // Counter array and sticky error state; reset drops all pending counts.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < DEPTH; r++) begin
                r_cnt[r] <= '0;
            end
            r_sb_err <= 1'b0;
        end else begin
            for (int r = 0; r < DEPTH; r++) begin
                r_cnt[r] <= w_cnt_nxt[r];
            end
            if (w_uflow) begin
                r_sb_err <= 1'b1;
            end
        end
    end

    assign sb_err = r_sb_err;

endmodule
`default_nettype wire

// File: rtl/regfile_mp_sb.sv
`default_nettype none
// ============================================================================
// Module      : regfile_mp_sb
// Description : Multi-port register file with write-through forwarding,
//               pending-write scoreboard and registered write-trace port.
// Revision    : 1.0  initial release
// ============================================================================
module regfile_mp_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = DEF_NUM_RD,
    parameter int NUM_WR = DEF_NUM_WR,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic [NUM_WR-1:0]        wr_clr,
    input  logic [NUM_WR*32-1:0]     wr_pc,
    input  logic                     iss_valid,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic                     iss_ready,
    output logic [NUM_WR-1:0]        trc_valid,
    output logic [NUM_WR*ADDR_W-1:0] trc_addr,
    output logic [NUM_WR*DATA_W-1:0] trc_data,
    output logic [NUM_WR*32-1:0]     trc_pc,
    output logic                     sb_err
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0]            r_mem [DEPTH];
    logic [MAX_WR-1:0]            w_en_pad;
    logic [MAX_WR*MAX_ADDR_W-1:0] w_wa_pad;
    logic [MAX_ADDR_W-1:0]        w_ra_pad [NUM_RD];
    hit_t                         w_hit    [NUM_RD];
    logic [NUM_WR-1:0]            r_trc_valid;
    logic [NUM_WR*ADDR_W-1:0]     r_trc_addr;
    logic [NUM_WR*DATA_W-1:0]     r_trc_data;
    logic [NUM_WR*32-1:0]         r_trc_pc;

    // Widen write-port vectors to the fixed layout the match helper expects.
    always_comb begin
        w_en_pad = '0;
        w_wa_pad = '0;
        for (int j = 0; j < NUM_WR; j++) begin
            w_en_pad[j]                             = wr_en[j];
            w_wa_pad[j*MAX_ADDR_W +: ADDR_W]        = wr_addr[j*ADDR_W +: ADDR_W];
        end
    end

    // Find the highest-priority write port matching each read address.
    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            w_ra_pad[i]         = '0;
            w_ra_pad[i][ADDR_W-1:0] = rd_addr[i*ADDR_W +: ADDR_W];
            w_hit[i]            = idx_hit(w_ra_pad[i], w_en_pad, w_wa_pad);
        end
    end

    // Read mux: x0 is zero, forwarded write data wins, else array contents.
    // Forwarding is suppressed in reset because those writes never land.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (rd_addr[i*ADDR_W +: ADDR_W] == '0) begin
                rd_data[i*DATA_W +: DATA_W] = '0;
            end else if (!reset && w_hit[i].hit) begin
                rd_data[i*DATA_W +: DATA_W] = wr_data[int'(w_hit[i].idx)*DATA_W +: DATA_W];
            end else begin
                rd_data[i*DATA_W +: DATA_W] = r_mem[rd_addr[i*ADDR_W +: ADDR_W]];
            end
        end
    end

    // Array write; later (higher-index) ports override on address collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < DEPTH; r++) begin
                r_mem[r] <= '0;
            end
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] != '0)) begin
                    r_mem[wr_addr[j*ADDR_W +: ADDR_W]] <= wr_data[j*DATA_W +: DATA_W];
                end
            end
        end
    end

    // One-cycle write trace per port, including collision losers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_trc_valid <= '0;
            r_trc_addr  <= '0;
            r_trc_data  <= '0;
            r_trc_pc    <= '0;
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                r_trc_valid[j] <= wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] != '0);
                if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] != '0)) begin
                    r_trc_addr[j*ADDR_W +: ADDR_W] <= wr_addr[j*ADDR_W +: ADDR_W];
                    r_trc_data[j*DATA_W +: DATA_W] <= wr_data[j*DATA_W +: DATA_W];
                    r_trc_pc[j*32 +: 32]           <= wr_pc[j*32 +: 32];
                end
            end
        end
    end

    assign trc_valid = r_trc_valid;
    assign trc_addr  = r_trc_addr;
    assign trc_data  = r_trc_data;
    assign trc_pc    = r_trc_pc;

    regfile_scoreboard #(
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD),
        .NUM_WR (NUM_WR),
        .CNT_W  (CNT_W)
    ) u_sb (
        .clk       (clk),
        .reset     (reset),
        .rd_addr   (rd_addr),
        .rd_busy   (rd_busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_clr    (wr_clr),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .iss_ready (iss_ready),
        .sb_err    (sb_err)
    );

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp_sb.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_mp_sb
// Description : Directed self-checking bench for regfile_mp_sb.
// Revision    : 1.0  initial release
// ============================================================================
module tb_regfile_mp_sb;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic [1:0]  wr_clr;
    logic [63:0] wr_pc;
    logic        iss_valid;
    logic [4:0]  iss_addr;
    logic        iss_ready;
    logic [1:0]  trc_valid;
    logic [9:0]  trc_addr;
    logic [63:0] trc_data;
    logic [63:0] trc_pc;
    logic        sb_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    regfile_mp_sb dut (
        .clk       (clk),
        .reset     (reset),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_clr    (wr_clr),
        .wr_pc     (wr_pc),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .iss_ready (iss_ready),
        .trc_valid (trc_valid),
        .trc_addr  (trc_addr),
        .trc_data  (trc_data),
        .trc_pc    (trc_pc),
        .sb_err    (sb_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_wr();
        wr_en  = 2'b00;
        wr_clr = 2'b00;
    endtask

    initial begin
        reset = 1'b1; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
        wr_clr = '0; wr_pc = '0; iss_valid = 1'b0; iss_addr = '0;
        tick(); tick();
        reset = 1'b0;
        rd_addr = {5'd7, 5'd5};
        iss_addr = 5'd3;
        #1;
        chk("rst_rd",     rd_data,   64'h0);
        chk("rst_trc",    64'(trc_valid), 64'h0);
        chk("rst_err",    64'(sb_err),    64'h0);
        chk("rst_busy",   64'(rd_busy),   64'h0);
        chk("rst_issrdy", 64'(iss_ready), 64'h1);

        // Single write to x5 with same-cycle forwarding and next-cycle trace
        wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'h12345678};
        wr_pc = {32'h0, 32'h0000_1000};
        #1;
        chk("fwd_x5",  64'(rd_data[31:0]), 64'h12345678);
        tick(); idle_wr(); #1;
        chk("rd_x5",   64'(rd_data[31:0]),  64'h12345678);
        chk("trc_v0",  64'(trc_valid),      64'h1);
        chk("trc_a0",  64'(trc_addr[4:0]),  64'h5);
        chk("trc_d0",  64'(trc_data[31:0]), 64'h12345678);
        chk("trc_pc0", 64'(trc_pc[31:0]),   64'h1000);

        // Colliding writes to x7: port1 wins, both ports trace
        wr_en = 2'b11; wr_addr = {5'd7, 5'd7};
        wr_data = {32'h5555FFFF, 32'hAAAA0000};
        wr_pc = {32'h0000_2004, 32'h0000_2000};
        #1;
        chk("fwd_x7",   64'(rd_data[63:32]), 64'h5555FFFF);
        tick(); idle_wr(); #1;
        chk("rd_x7",    64'(rd_data[63:32]), 64'h5555FFFF);
        chk("trc_v01",  64'(trc_valid),      64'h3);
        chk("trc_d0c",  64'(trc_data[31:0]), 64'hAAAA0000);
        chk("trc_d1c",  64'(trc_data[63:32]), 64'h5555FFFF);
        chk("trc_pc1",  64'(trc_pc[63:32]),  64'h2004);

        // x0 stays zero, is never traced or busy, issue accepted
        rd_addr = {5'd7, 5'd0};
        wr_en = 2'b01; wr_addr = {5'd0, 5'd0}; wr_data = {32'h0, 32'hFFFFFFFF};
        iss_valid = 1'b1; iss_addr = 5'd0;
        #1;
        chk("x0_fwd",   64'(rd_data[31:0]), 64'h0);
        chk("x0_issrdy", 64'(iss_ready),    64'h1);
        chk("x0_busy",  64'(rd_busy[0]),    64'h0);
        tick(); idle_wr(); iss_valid = 1'b0; #1;
        chk("x0_rd",    64'(rd_data[31:0]), 64'h0);
        chk("x0_trc",   64'(trc_valid),     64'h0);
        chk("x0_busy2", 64'(rd_busy[0]),    64'h0);

        // Fill the x3 counter to MAX=3
        rd_addr = {5'd7, 5'd3};
        iss_valid = 1'b1; iss_addr = 5'd3;
        #1;
        chk("x3_rdy0",  64'(iss_ready),   64'h1);
        chk("x3_busy0", 64'(rd_busy[0]),  64'h0);
        tick(); tick(); tick();
        chk("x3_full",  64'(iss_ready),   64'h0);
        chk("x3_busy3", 64'(rd_busy[0]),  64'h1);
        // Issue plus clear at MAX: accepted, count holds at 3
        wr_en = 2'b01; wr_clr = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = 64'h33;
        #1;
        chk("x3_iscl_rdy",  64'(iss_ready),  64'h1);
        chk("x3_iscl_busy", 64'(rd_busy[0]), 64'h1);
        tick(); idle_wr(); #1;
        chk("x3_hold",  64'(iss_ready),   64'h0);
        // Three clears; busy drops in the cycle of the last one
        iss_valid = 1'b0;
        wr_en = 2'b01; wr_clr = 2'b01;
        #1;
        chk("x3_cl1_busy", 64'(rd_busy[0]), 64'h1);
        tick(); tick();
        chk("x3_cl3_busy", 64'(rd_busy[0]), 64'h0);
        tick(); idle_wr(); #1;
        chk("x3_done_busy", 64'(rd_busy[0]), 64'h0);
        chk("x3_done_err",  64'(sb_err),     64'h0);

        // Underflow on x9: sticky error, count saturates at 0
        rd_addr = {5'd7, 5'd9};
        wr_en = 2'b01; wr_clr = 2'b01; wr_addr = {5'd0, 5'd9}; wr_data = 64'h99;
        tick(); idle_wr(); #1;
        chk("uf_err",   64'(sb_err),         64'h1);
        chk("uf_busy",  64'(rd_busy[0]),     64'h0);
        chk("uf_data",  64'(rd_data[31:0]),  64'h99);
        iss_valid = 1'b1; iss_addr = 5'd9;
        tick(); iss_valid = 1'b0; #1;
        chk("uf_iss_busy", 64'(rd_busy[0]), 64'h1);
        wr_en = 2'b01; wr_clr = 2'b01;
        tick(); idle_wr(); #1;
        chk("uf_cl_busy", 64'(rd_busy[0]), 64'h0);
        chk("uf_sticky",  64'(sb_err),     64'h1);

        // Pending x4 counts and a reset-cycle write are discarded by reset
        rd_addr = {5'd7, 5'd4};
        iss_valid = 1'b1; iss_addr = 5'd4;
        tick(); tick(); iss_valid = 1'b0; #1;
        chk("x4_busy", 64'(rd_busy[0]), 64'h1);
        reset = 1'b1;
        wr_en = 2'b01; wr_addr = {5'd0, 5'd6}; wr_data = 64'h66;
        #1;
        chk("rst_iss_rdy", 64'(iss_ready), 64'h1);
        tick();
        reset = 1'b0; idle_wr(); #1;
        chk("post_busy4", 64'(rd_busy[0]), 64'h0);
        chk("post_trc",   64'(trc_valid),  64'h0);
        chk("post_err",   64'(sb_err),     64'h0);
        chk("post_rd74",  rd_data,         64'h0);
        rd_addr = {5'd5, 5'd6};
        #1;
        chk("post_rd56",  rd_data,         64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
